// File: rtl/cp_strip_symbol_buffer.sv
// Cyclic-prefix stripper with a two-bank ping-pong symbol store.
// Completed symbols are replayed as valid/ready bursts with out_last on the final sample.
module cp_strip_symbol_buffer #(
    parameter int I_DATA = 32,
    parameter int N      = 64,
    parameter int CP_LEN = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [I_DATA-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [I_DATA-1:0] out_data,
    output logic              out_last,
    output logic              overflow
);
    localparam int TOT = N + CP_LEN;
    localparam int WCW = (TOT > 1) ? $clog2(TOT) : 1;
    localparam int RCW = $clog2(N);

    typedef enum logic {IDLE, STREAM} state_t;

    logic [I_DATA-1:0] mem [2][N];
    logic [1:0]        full, full_nxt;
    logic [WCW-1:0]    wr_cnt;
    logic [RCW-1:0]    wr_addr;
    logic              wr_bank, rd_bank;
    logic [RCW-1:0]    rd_cnt, rd_nxt;
    logic              accept, wr_store, wr_end;
    logic              rd_at_end, rd_start, rd_load, rd_adv, rd_done;
    state_t            state, state_nxt;

    assign in_ready  = !full[wr_bank];
    assign accept    = in_valid && in_ready;
    assign wr_store  = accept && (wr_cnt >= WCW'(CP_LEN));
    assign wr_end    = accept && (wr_cnt == WCW'(TOT - 1));
    assign wr_addr   = RCW'(wr_cnt - WCW'(CP_LEN));
    assign rd_at_end = (rd_cnt == RCW'(N - 1));
    assign rd_nxt    = rd_cnt + RCW'(1);

    always_ff @(posedge clk) begin
        if (reset && wr_store)
            mem[wr_bank][wr_addr] <= in_data;
    end

    // Prefix samples only advance the counter; useful samples land at wr_cnt-CP_LEN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_cnt   <= '0;
            wr_bank  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept)
                wr_cnt <= wr_end ? '0 : wr_cnt + WCW'(1);
            if (wr_end)
                wr_bank <= ~wr_bank;
            if (in_valid && !in_ready)
                overflow <= 1'b1;
        end
    end

    // Writer and reader only ever touch different banks when both fire.
    always_comb begin
        full_nxt = full;
        if (rd_done)
            full_nxt[rd_bank] = 1'b0;
        if (wr_end)
            full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            full <= '0;
        else
            full <= full_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (full[rd_bank]) state_nxt = STREAM;
            STREAM:  if (out_valid && out_ready && rd_at_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_start = 1'b0;
        rd_load  = 1'b0;
        rd_adv   = 1'b0;
        rd_done  = 1'b0;
        case (state)
            IDLE:   rd_start = full[rd_bank];
            STREAM: begin
                rd_load = !out_valid;
                rd_adv  = out_valid && out_ready && !rd_at_end;
                rd_done = out_valid && out_ready && rd_at_end;
            end
            default: ;
        endcase
    end

    // Output registers lag STREAM entry by one cycle; the next word is fetched on handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (rd_start)
                rd_cnt <= '0;
            if (rd_load) begin
                out_valid <= 1'b1;
                out_data  <= mem[rd_bank][rd_cnt];
                out_last  <= rd_at_end;
            end
            if (rd_adv) begin
                rd_cnt   <= rd_nxt;
                out_data <= mem[rd_bank][rd_nxt];
                out_last <= (rd_nxt == RCW'(N - 1));
            end
            if (rd_done) begin
                out_valid <= 1'b0;
                out_data  <= '0;
                out_last  <= 1'b0;
                rd_bank   <= ~rd_bank;
            end
        end
    end
endmodule

// File: tb/tb_cp_strip_symbol_buffer.sv
// Scoreboard bench for cp_strip_symbol_buffer (N=8, CP_LEN=2, 32-bit samples).
// Expected useful samples are queued at input acceptance and popped on each output handshake.
module tb_cp_strip_symbol_buffer;
    localparam int I_DATA = 32;
    localparam int N      = 8;
    localparam int CP_LEN = 2;
    localparam int TOT    = N + CP_LEN;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [I_DATA-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [I_DATA-1:0] out_data;
    logic              out_last;
    logic              overflow;

    cp_strip_symbol_buffer #(.I_DATA(I_DATA), .N(N), .CP_LEN(CP_LEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [I_DATA:0] sb[$];
    int nvec = 0, nerr = 0;
    int scnt = 0, nsent = 0, ndrop = 0, first_drop = -1, last_edge = 0, npop = 0;
    logic              stall_prev = 1'b0;
    logic [I_DATA-1:0] prev_data;
    logic              prev_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: count accepted samples per symbol, queue the useful ones.
    task automatic send(input logic [I_DATA-1:0] d);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        if (in_ready) begin
            if (scnt >= CP_LEN) sb.push_back({scnt == TOT - 1, d});
            if (scnt == TOT - 1) last_edge = cyc + 1;
            scnt = (scnt == TOT - 1) ? 0 : scnt + 1;
        end else begin
            if (first_drop < 0) first_drop = nsent;
            ndrop++;
        end
        nsent++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
                chk("stall_last", out_last, prev_last);
            end
            if (!out_valid) begin
                chk("idle_data", out_data, 0);
                chk("idle_last", out_last, 0);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_out", sb.size(), 1);
                else begin
                    logic [I_DATA:0] e;
                    e = sb.pop_front();
                    chk("data", out_data, e[I_DATA-1:0]);
                    chk("last", out_last, e[I_DATA]);
                end
                npop++;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_in_ready", in_ready, 1);

        // single contiguous symbol with latency check
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(i);
        idle(1);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("latency", cyc - last_edge, 2);
        drain();
        chk("t1_overflow", overflow, 0);

        // three symbols back-to-back
        ndrop = 0; base = npop;
        for (int i = 0; i < 30; i++) send(i);
        drain();
        chk("t2_drops", ndrop, 0);
        chk("t2_count", npop - base, 24);
        chk("t2_overflow", overflow, 0);

        // output stalled: both banks fill, later samples dropped
        out_ready = 1'b0; ndrop = 0; nsent = 0; first_drop = -1; base = npop;
        for (int i = 0; i < 30; i++) send(i);
        idle(1);
        chk("t3_first_drop", first_drop, 20);
        chk("t3_drops", ndrop, 10);
        chk("t3_overflow", overflow, 1);
        out_ready = 1'b1;
        drain();
        chk("t3_count", npop - base, 16);
        repeat (5) begin
            @(negedge clk);
            chk("t3_quiet", out_valid, 0);
        end

        // back-pressure toggling during a burst
        base = npop;
        for (int i = 0; i < 10; i++) send(8'h40 + i);
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        drain();
        chk("t4_count", npop - base, 8);

        // random input gaps, including inside the prefix
        base = npop;
        for (int i = 0; i < 10; i++) begin
            idle((i == 1) ? 2 : int'($urandom_range(0, 2)));
            send(i);
        end
        drain();
        chk("t5_count", npop - base, 8);

        // reset mid-burst, then a fresh symbol
        base = npop;
        for (int i = 0; i < 10; i++) send(8'h80 + i);
        idle(1);
        for (int i = 0; i < 50 && npop != base + 4; i++) begin
            @(posedge clk); #1;
        end
        chk("t6_reached_s4", npop - base, 4);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        scnt = 0;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_in_ready", in_ready, 1);
        base = npop;
        for (int i = 0; i < 10; i++) send(8'hC0 + i);
        drain();
        chk("t6_count", npop - base, 8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
